// File: rtl/gcd_pkg.sv
// Shared encodings for the GCD job dispatcher: FSM states, default width, error codes.
package gcd_pkg;

  localparam int GCD_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Watchdog counter: clear wins over enable; expire is high while count == TIMEOUT-1.
// Latency: expire reflects the registered count; no backpressure.
module gcd_timeout_ctr #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Launches the GCD core per operand pair, bypasses zero operands, aborts a hung core.
// Latency: bypass 1 cycle, core path done+1; result held in RESP until out_ready.
module gcd_job_dispatcher
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             core_start,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [W-1:0]     core_gcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gcd,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_cnt
);

  state_e           state_q, state_d;
  logic [W-1:0]     core_a_q, core_a_d;
  logic [W-1:0]     core_b_q, core_b_d;
  logic [W-1:0]     out_gcd_q, out_gcd_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
  logic             tmr_clr, tmr_en, tmr_expire, abort;

  gcd_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    core_a_d  = core_a_q;
    core_b_d  = core_b_q;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err_q;
    job_cnt_d = job_cnt_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          core_a_d = in_a;
          core_b_d = in_b;
          // A zero operand would never terminate the subtract loop.
          if (in_a == '0 || in_b == '0) begin
            out_gcd_d = in_a | in_b;
            out_err_d = (in_a == '0 && in_b == '0) ? ERR_FAIL : ERR_NONE;
            state_d   = S_RESP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        tmr_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (core_done) begin
          out_gcd_d = core_gcd;
          out_err_d = ERR_NONE;
          state_d   = S_RESP;
        end else if (tmr_expire) begin
          abort     = 1'b1;
          out_gcd_d = '0;
          out_err_d = ERR_FAIL;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          job_cnt_d = job_cnt_q + CNT_W'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      core_a_q  <= '0;
      core_b_q  <= '0;
      out_gcd_q <= '0;
      out_err_q <= 1'b0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      core_a_q  <= core_a_d;
      core_b_q  <= core_b_d;
      out_gcd_q <= out_gcd_d;
      out_err_q <= out_err_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  assign in_ready   = resetn && (state_q == S_IDLE);
  assign core_start = (state_q == S_LOAD);
  assign core_clr   = !resetn || abort;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_valid  = (state_q == S_RESP);
  assign out_gcd    = out_gcd_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q != S_IDLE);
  assign job_cnt    = job_cnt_q;

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Directed bench for gcd_job_dispatcher with a behavioural GCD core and a result scoreboard.
module tb_gcd_job_dispatcher;

  localparam int W       = 4;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [W-1:0] gcd;
    logic         err;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             core_start;
  logic [W-1:0]     core_a;
  logic [W-1:0]     core_b;
  logic             core_clr;
  logic             core_done = 1'b0;
  logic [W-1:0]     core_gcd = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_gcd;
  logic             out_err;
  logic             busy;
  logic [CNT_W-1:0] job_cnt;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mdl_delay = 5;
  int   mdl_cnt = 0;
  int   n_starts = 0;
  int   waited;
  int   starts_snap;

  always #5 clk = ~clk;

  gcd_job_dispatcher #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_clr   (core_clr),
    .core_done  (core_done),
    .core_gcd   (core_gcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .busy       (busy),
    .job_cnt    (job_cnt)
  );

  function automatic int gcd_ref(int a, int b);
    int t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // Core model: done pulses on WAIT cycle mdl_delay after start; delay 0 = hung core.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (core_start) begin
      n_starts++;
      mdl_cnt = mdl_delay;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        core_done = 1'b1;
        core_gcd  = W'(gcd_ref(int'(core_a), int'(core_b)));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eg, input logic ee);
    exp_t e;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("send_in_ready", 32'(in_ready), 32'd1);
    e.gcd = eg;
    e.err = ee;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(output int nwait);
    exp_t e;
    out_ready = 1'b1;
    nwait = 0;
    while (!out_valid && nwait < 100) begin
      tick();
      nwait++;
    end
    chk("recv_out_valid", 32'(out_valid), 32'd1);
    chk("recv_sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("recv_out_gcd", 32'(out_gcd), 32'(e.gcd));
      chk("recv_out_err", 32'(out_err), 32'(e.err));
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_clr", 32'(core_clr), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_job_cnt", 32'(job_cnt), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_core_clr", 32'(core_clr), 32'd0);

    // 1: core path 12,8
    mdl_delay = 5;
    send(4'd12, 4'd8, 4'd4, 1'b0);
    chk("t1_core_start", 32'(core_start), 32'd1);
    chk("t1_core_a", 32'(core_a), 32'd12);
    chk("t1_core_b", 32'(core_b), 32'd8);
    chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
    recv(waited);
    chk("t1_latency", 32'(waited), 32'd6);
    chk("t1_starts", 32'(n_starts), 32'd1);
    chk("t1_job_cnt", 32'(job_cnt), 32'd1);
    chk("t1_in_ready_after", 32'(in_ready), 32'd1);

    // 2: zero-operand bypass
    send(4'd0, 4'd9, 4'd9, 1'b0);
    chk("t2_no_start", 32'(core_start), 32'd0);
    recv(waited);
    chk("t2_latency", 32'(waited), 32'd0);
    send(4'd0, 4'd0, 4'd0, 1'b1);
    recv(waited);
    chk("t2_starts", 32'(n_starts), 32'd1);
    chk("t2_job_cnt", 32'(job_cnt), 32'd3);

    // 3: output backpressure
    mdl_delay = 3;
    send(4'd15, 4'd5, 4'd5, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    in_a     = 4'd7;
    in_b     = 4'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_gcd", 32'(out_gcd), 32'd5);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    recv(waited);
    chk("t3_starts", 32'(n_starts), 32'd2);
    chk("t3_job_cnt", 32'(job_cnt), 32'd4);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: hung core -> watchdog abort on WAIT cycle TIMEOUT
    mdl_delay = 0;
    send(4'd3, 4'd7, 4'd0, 1'b1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("t4_core_clr", 32'(core_clr), 32'(i == TIMEOUT));
    end
    recv(waited);
    chk("t4_latency", 32'(waited), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd1);

    // 5: reset during WAIT, late done ignored
    mdl_delay = 10;
    send(4'd9, 4'd6, 4'd3, 1'b0);
    tick();
    tick();
    tick();
    chk("t5_busy_wait", 32'(busy), 32'd1);
    resetn = 1'b0;
    tick();
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_job_cnt", 32'(job_cnt), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_core_clr", 32'(core_clr), 32'd1);
    resetn = 1'b1;
    void'(sb.pop_back());
    starts_snap = n_starts;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_no_output", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_starts", 32'(n_starts), 32'(starts_snap));

    // 6: done coincides with timeout cycle
    mdl_delay = TIMEOUT;
    send(4'd12, 4'd14, 4'd2, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("t6_no_core_clr", 32'(core_clr), 32'd0);
    end
    recv(waited);
    chk("t6_latency", 32'(waited), 32'd1);
    chk("t6_job_cnt", 32'(job_cnt), 32'd1);

    // job_cnt wrap
    for (int i = 0; i < 255; i++) begin
      send(4'(i % 15 + 1), 4'd0, 4'(i % 15 + 1), 1'b0);
      recv(waited);
      if (i == 253) chk("wrap_pre", 32'(job_cnt), 32'd255);
    end
    chk("wrap_zero", 32'(job_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
